// File: rtl/voice_allocator_if.sv
// Byte-stream handshake between the SPI slave (master side) and the voice allocator (slave side).
interface voice_allocator_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_overrun;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  rx_overrun
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output rx_overrun
    );
endinterface

// File: rtl/voice_allocator.sv
// MIDI note-on/off parser and polyphonic voice allocator with oldest-voice stealing.
//
// state  | meaning
// IDLE   | waiting for status, or a note byte under running status
// DATA1  | status seen, waiting for note byte
// DATA2  | note latched, waiting for velocity byte
// SCAN   | one voice examined per cycle for match / free / oldest
// COMMIT | voice registers updated, retrig/steal pulsed next cycle
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int CHANNEL    = 0,
    parameter int AGE_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    voice_allocator_if.slave        rx,
    output logic [8*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_velocity,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_retrig,
    output logic                    steal
);

    localparam int                IDX_W       = (NUM_VOICES > 2) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_VOICES - 1);
    localparam logic [7:0]        NOTE_ON_ST  = {4'h9, 4'(CHANNEL)};
    localparam logic [7:0]        NOTE_OFF_ST = {4'h8, 4'(CHANNEL)};
    localparam logic [AGE_W-1:0]  AGE_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA1,
        S_DATA2,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t state_q, state_d;

    logic             rs_valid_q, rs_valid_d;
    logic             rs_on_q, rs_on_d;
    logic [6:0]       note_q, note_d;
    logic [6:0]       vel_q, vel_d;
    logic             ev_on_q, ev_on_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;

    logic             match_found_q, match_found_d;
    logic [IDX_W-1:0] match_idx_q, match_idx_d;
    logic             free_found_q, free_found_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic             oldest_found_q, oldest_found_d;
    logic [IDX_W-1:0] oldest_idx_q, oldest_idx_d;
    logic [AGE_W-1:0] oldest_age_q, oldest_age_d;
    logic [NUM_VOICES-1:0] mark_q, mark_d;

    logic [NUM_VOICES-1:0][7:0]       v_note_q, v_note_d;
    logic [NUM_VOICES-1:0][6:0]       v_vel_q, v_vel_d;
    logic [NUM_VOICES-1:0]            v_gate_q, v_gate_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0] v_age_q, v_age_d;
    logic [NUM_VOICES-1:0]            retrig_q, retrig_d;
    logic                             steal_q, steal_d;
    logic                             overrun_q, overrun_d;

    logic             rx_ready;
    logic             byte_take;
    logic             is_rt;
    logic             is_status;
    logic             is_data;
    logic             is_ours_on;
    logic             is_ours_off;
    logic [7:0]       rx_byte;
    logic [IDX_W-1:0] tgt_idx;
    logic             tgt_steal;

    always_comb begin
        rx_byte     = rx.rx_data;
        byte_take   = rx.rx_valid && rx_ready;
        is_rt       = rx_byte >= 8'hF8;
        is_status   = rx_byte[7] && !is_rt;
        is_data     = !rx_byte[7];
        is_ours_on  = rx_byte == NOTE_ON_ST;
        is_ours_off = rx_byte == NOTE_OFF_ST;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DATA1, S_DATA2: begin
                if (byte_take && is_status) begin
                    state_d = (is_ours_on || is_ours_off) ? S_DATA1 : S_IDLE;
                end else if (byte_take && is_data) begin
                    if (state_q == S_DATA2) begin
                        state_d = S_SCAN;
                    end else if (state_q == S_DATA1 || rs_valid_q) begin
                        state_d = S_DATA2;
                    end
                end
            end
            S_SCAN: begin
                if (scan_idx_q == LAST_IDX) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rx_ready = (state_q == S_IDLE) || (state_q == S_DATA1) || (state_q == S_DATA2);
    end

    assign rx.rx_ready     = rx_ready;
    assign rx.rx_overrun   = overrun_q;
    assign voice_note      = v_note_q;
    assign voice_velocity  = v_vel_q;
    assign voice_gate      = v_gate_q;
    assign voice_retrig    = retrig_q;
    assign steal           = steal_q;

    // A held note is re-struck in place; otherwise fill a free voice before stealing.
    always_comb begin
        tgt_steal = 1'b0;
        if (match_found_q) begin
            tgt_idx = match_idx_q;
        end else if (free_found_q) begin
            tgt_idx = free_idx_q;
        end else begin
            tgt_idx   = oldest_idx_q;
            tgt_steal = oldest_found_q;
        end
    end

    always_comb begin
        rs_valid_d     = rs_valid_q;
        rs_on_d        = rs_on_q;
        note_d         = note_q;
        vel_d          = vel_q;
        ev_on_d        = ev_on_q;
        scan_idx_d     = scan_idx_q;
        match_found_d  = match_found_q;
        match_idx_d    = match_idx_q;
        free_found_d   = free_found_q;
        free_idx_d     = free_idx_q;
        oldest_found_d = oldest_found_q;
        oldest_idx_d   = oldest_idx_q;
        oldest_age_d   = oldest_age_q;
        mark_d         = mark_q;
        v_note_d       = v_note_q;
        v_vel_d        = v_vel_q;
        v_gate_d       = v_gate_q;
        v_age_d        = v_age_q;
        retrig_d       = '0;
        steal_d        = 1'b0;
        overrun_d      = rx.rx_valid && !rx_ready;

        unique case (state_q)
            S_IDLE, S_DATA1, S_DATA2: begin
                if (byte_take && is_status) begin
                    rs_valid_d = is_ours_on || is_ours_off;
                    rs_on_d    = is_ours_on;
                end else if (byte_take && is_data) begin
                    if (state_q == S_DATA2) begin
                        vel_d          = rx_byte[6:0];
                        ev_on_d        = rs_on_q && (rx_byte[6:0] != 7'd0);
                        scan_idx_d     = '0;
                        match_found_d  = 1'b0;
                        free_found_d   = 1'b0;
                        oldest_found_d = 1'b0;
                        mark_d         = '0;
                    end else if (state_q == S_DATA1 || rs_valid_q) begin
                        note_d = rx_byte[6:0];
                    end
                end
            end
            S_SCAN: begin
                scan_idx_d = scan_idx_q + IDX_W'(1);
                if (v_gate_q[scan_idx_q] && v_note_q[scan_idx_q] == {1'b0, note_q}) begin
                    mark_d[scan_idx_q] = 1'b1;
                    if (!match_found_q) begin
                        match_found_d = 1'b1;
                        match_idx_d   = scan_idx_q;
                    end
                end
                if (!v_gate_q[scan_idx_q] && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                // Strict compare keeps the lowest index on equal ages.
                if (v_gate_q[scan_idx_q] &&
                    (!oldest_found_q || v_age_q[scan_idx_q] > oldest_age_q)) begin
                    oldest_found_d = 1'b1;
                    oldest_idx_d   = scan_idx_q;
                    oldest_age_d   = v_age_q[scan_idx_q];
                end
            end
            S_COMMIT: begin
                if (ev_on_q) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) == tgt_idx) begin
                            v_vel_d[i]  = vel_q;
                            v_age_d[i]  = '0;
                            retrig_d[i] = 1'b1;
                            if (!match_found_q) begin
                                v_note_d[i] = {1'b0, note_q};
                                v_gate_d[i] = 1'b1;
                            end
                        end else if (v_gate_q[i] && v_age_q[i] != AGE_MAX) begin
                            v_age_d[i] = v_age_q[i] + AGE_W'(1);
                        end
                    end
                    steal_d = tgt_steal;
                end else begin
                    v_gate_d = v_gate_q & ~mark_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_valid_q     <= 1'b0;
            rs_on_q        <= 1'b0;
            note_q         <= '0;
            vel_q          <= '0;
            ev_on_q        <= 1'b0;
            scan_idx_q     <= '0;
            match_found_q  <= 1'b0;
            match_idx_q    <= '0;
            free_found_q   <= 1'b0;
            free_idx_q     <= '0;
            oldest_found_q <= 1'b0;
            oldest_idx_q   <= '0;
            oldest_age_q   <= '0;
            mark_q         <= '0;
            v_note_q       <= '0;
            v_vel_q        <= '0;
            v_gate_q       <= '0;
            v_age_q        <= '0;
            retrig_q       <= '0;
            steal_q        <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            rs_valid_q     <= rs_valid_d;
            rs_on_q        <= rs_on_d;
            note_q         <= note_d;
            vel_q          <= vel_d;
            ev_on_q        <= ev_on_d;
            scan_idx_q     <= scan_idx_d;
            match_found_q  <= match_found_d;
            match_idx_q    <= match_idx_d;
            free_found_q   <= free_found_d;
            free_idx_q     <= free_idx_d;
            oldest_found_q <= oldest_found_d;
            oldest_idx_q   <= oldest_idx_d;
            oldest_age_q   <= oldest_age_d;
            mark_q         <= mark_d;
            v_note_q       <= v_note_d;
            v_vel_q        <= v_vel_d;
            v_gate_q       <= v_gate_d;
            v_age_q        <= v_age_d;
            retrig_q       <= retrig_d;
            steal_q        <= steal_d;
            overrun_q      <= overrun_d;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed message table, corner sequences and randomized traffic vs a message-level model.
module tb_voice_allocator;
    localparam int NV = 8;

    logic clk;
    logic reset;
    voice_allocator_if rx_if ();
    logic [8*NV-1:0] voice_note;
    logic [7*NV-1:0] voice_velocity;
    logic [NV-1:0]   voice_gate;
    logic [NV-1:0]   voice_retrig;
    logic            steal;

    voice_allocator #(.NUM_VOICES(NV), .CHANNEL(0), .AGE_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx_if),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_gate     (voice_gate),
        .voice_retrig   (voice_retrig),
        .steal          (steal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // message-level reference model
    logic [6:0] m_note [NV];
    logic [6:0] m_vel  [NV];
    logic       m_gate [NV];
    int         m_age  [NV];
    logic [NV-1:0] e_retrig;
    logic          e_steal;
    int            rs;   // 0 none, 1 note-on, 2 note-off

    typedef struct {
        int          nb;
        logic [31:0] bytes;
        logic [7:0]  gate;
        logic [7:0]  retrig;
        logic        stl;
        int          v;
        logic [7:0]  note;
        logic [6:0]  vel;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = '0; m_vel[i] = '0; m_gate[i] = 1'b0; m_age[i] = 0;
        end
        rs = 0;
    endtask

    task automatic model_msg(input bit on_st, input logic [6:0] n, input logic [6:0] v);
        int tgt;
        tgt = -1;
        e_retrig = '0;
        e_steal = 1'b0;
        if (on_st && v != 0) begin
            bit fresh;
            fresh = 1'b0;
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
            if (tgt < 0) begin
                fresh = 1'b1;
                for (int i = 0; i < NV; i++)
                    if (tgt < 0 && !m_gate[i]) tgt = i;
            end
            if (tgt < 0) begin
                e_steal = 1'b1;
                for (int i = 0; i < NV; i++)
                    if (m_gate[i] && (tgt < 0 || m_age[i] > m_age[tgt])) tgt = i;
            end
            for (int i = 0; i < NV; i++)
                if (i != tgt && m_gate[i] && m_age[i] < 255) m_age[i]++;
            if (fresh) begin
                m_note[tgt] = n;
                m_gate[tgt] = 1'b1;
            end
            m_vel[tgt] = v;
            m_age[tgt] = 0;
            e_retrig[tgt] = 1'b1;
        end else begin
            for (int i = 0; i < NV; i++)
                if (m_gate[i] && m_note[i] == n) m_gate[i] = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = b;
        @(posedge clk);
        #1;
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_if.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Called one cycle after the velocity byte; returns in the cycle retrig/steal are visible.
    task automatic to_commit();
        repeat (NV) @(posedge clk);
        #1;
        chk("pre_pulse", {steal, voice_retrig}, '0);
        chk("pre_ready", rx_if.rx_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("ready_back", rx_if.rx_ready, 1'b1);
    endtask

    task automatic after_commit();
        @(posedge clk);
        #1;
        chk("post_pulse", {steal, voice_retrig}, '0);
    endtask

    task automatic check_model(input string tag);
        logic [8*NV-1:0] en;
        logic [7*NV-1:0] ev;
        logic [NV-1:0]   eg;
        for (int i = 0; i < NV; i++) begin
            en[8*i +: 8] = {1'b0, m_note[i]};
            ev[7*i +: 7] = m_vel[i];
            eg[i]        = m_gate[i];
        end
        chk({tag, "_gate"}, voice_gate, eg);
        chk({tag, "_retrig"}, voice_retrig, e_retrig);
        chk({tag, "_steal"}, steal, e_steal);
        chk({tag, "_note"}, voice_note, en);
        chk({tag, "_vel"}, voice_velocity, ev);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [NV-1:0] seen_retrig;
        logic [NV-1:0] seen_gate;

        tbl[0] = '{3, 32'h903C6400, 8'h01, 8'h01, 1'b0, 0, 8'h3C, 7'h64};
        tbl[1] = '{2, 32'h3E500000, 8'h03, 8'h02, 1'b0, 1, 8'h3E, 7'h50};
        tbl[2] = '{3, 32'h803C0000, 8'h02, 8'h00, 1'b0, 0, 8'h3C, 7'h64};
        tbl[3] = '{4, 32'h90F84046, 8'h03, 8'h01, 1'b0, 0, 8'h40, 7'h46};
        tbl[4] = '{3, 32'h90400000, 8'h02, 8'h00, 1'b0, 0, 8'h40, 7'h46};
        tbl[5] = '{3, 32'h903E3200, 8'h02, 8'h02, 1'b0, 1, 8'h3E, 7'h32};
        tbl[6] = '{2, 32'h3E000000, 8'h00, 8'h00, 1'b0, 1, 8'h3E, 7'h32};
        tbl[7] = '{3, 32'h903C6400, 8'h01, 8'h01, 1'b0, 0, 8'h3C, 7'h64};

        reset = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = '0;
        do_reset();

        chk("rst_gate", voice_gate, '0);
        chk("rst_note", voice_note, '0);
        chk("rst_vel", voice_velocity, '0);
        chk("rst_pulse", {steal, voice_retrig}, '0);
        chk("rst_ready", rx_if.rx_ready, 1'b1);
        chk("rst_overrun", rx_if.rx_overrun, 1'b0);

        // directed message table
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < tbl[t].nb; k++) begin
                logic [31:0] w;
                w = tbl[t].bytes;
                send_byte(w[31-8*k -: 8]);
            end
            to_commit();
            chk($sformatf("tbl%0d_gate", t), voice_gate, tbl[t].gate);
            chk($sformatf("tbl%0d_retrig", t), voice_retrig, tbl[t].retrig);
            chk($sformatf("tbl%0d_steal", t), steal, tbl[t].stl);
            chk($sformatf("tbl%0d_note", t), voice_note[8*tbl[t].v +: 8], tbl[t].note);
            chk($sformatf("tbl%0d_vel", t), voice_velocity[7*tbl[t].v +: 7], tbl[t].vel);
            after_commit();
        end

        // wrong channel: no scan, no change
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
        seen_retrig = '0;
        for (int c = 0; c < NV + 4; c++) begin
            @(posedge clk); #1;
            seen_retrig |= voice_retrig;
        end
        chk("wrongch_retrig", seen_retrig, '0);
        chk("wrongch_gate", voice_gate, 8'h01);
        chk("wrongch_ready", rx_if.rx_ready, 1'b1);

        // overrun during SCAN; dropped byte must not become the next note
        do_reset();
        send_byte(8'h90); send_byte(8'd60); send_byte(8'd100);
        model_msg(1'b1, 7'd60, 7'd100);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = 8'h3E;
        @(posedge clk); #1;
        rx_if.rx_valid = 1'b0;
        chk("overrun_pulse", rx_if.rx_overrun, 1'b1);
        @(posedge clk); #1;
        chk("overrun_once", rx_if.rx_overrun, 1'b0);
        repeat (NV - 1) @(posedge clk);
        #1;
        check_model("ovr_commit");
        after_commit();
        send_byte(8'd64); send_byte(8'd80);
        model_msg(1'b1, 7'd64, 7'd80);
        to_commit();
        check_model("ovr_next");
        after_commit();

        // stealing: nine distinct notes then a tenth
        do_reset();
        for (int n = 40; n <= 49; n++) begin
            send_byte(8'h90); send_byte(8'(n)); send_byte(8'd100);
            model_msg(1'b1, 7'(n), 7'd100);
            to_commit();
            check_model($sformatf("steal_n%0d", n));
            if (n == 48) begin
                chk("steal9_pulse", steal, 1'b1);
                chk("steal9_retrig", voice_retrig, 8'h01);
                chk("steal9_note", voice_note[7:0], 8'd48);
            end
            if (n == 49) begin
                chk("steal10_pulse", steal, 1'b1);
                chk("steal10_retrig", voice_retrig, 8'h02);
                chk("steal10_note", voice_note[15:8], 8'd49);
            end
            after_commit();
        end

        // reset asserted in the third SCAN cycle
        do_reset();
        send_byte(8'h90); send_byte(8'd60); send_byte(8'd100);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen_retrig = '0;
        seen_gate = '0;
        for (int c = 0; c < NV + 4; c++) begin
            seen_retrig |= voice_retrig;
            seen_gate   |= voice_gate;
            @(posedge clk); #1;
        end
        chk("midrst_retrig", seen_retrig, '0);
        chk("midrst_gate", seen_gate, '0);
        chk("midrst_note", voice_note, '0);
        chk("midrst_ready", rx_if.rx_ready, 1'b1);
        model_reset();

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                send_byte(($urandom_range(0, 1) != 0) ? 8'h91 : 8'h81);
                send_byte(8'(60 + $urandom_range(0, 11)));
                send_byte(8'(1 + $urandom_range(0, 126)));
                rs = 0;
                repeat (3) @(posedge clk);
                #1;
                e_retrig = '0;
                e_steal = 1'b0;
                check_model("rnd_wrongch");
            end else begin
                bit on_st;
                logic [6:0] n;
                logic [6:0] v;
                on_st = (r < 70);
                n = 7'(60 + $urandom_range(0, 11));
                v = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
                q.delete();
                if (!(rs == (on_st ? 1 : 2) && $urandom_range(0, 1) != 0))
                    q.push_back(on_st ? 8'h90 : 8'h80);
                q.push_back({1'b0, n});
                q.push_back({1'b0, v});
                if ($urandom_range(0, 4) == 0)
                    q.insert($urandom_range(0, q.size() - 1), 8'hF8);
                foreach (q[k]) send_byte(q[k]);
                rs = on_st ? 1 : 2;
                model_msg(on_st, n, v);
                to_commit();
                check_model("rnd");
                after_commit();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
